// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR packet buffer slice.
package fir_pkg;

  localparam int unsigned HDR_WORDS       = 3;
  localparam int unsigned TRL_WORDS       = 1;
  localparam int unsigned MIN_PKT_DEFAULT = HDR_WORDS + TRL_WORDS;
  localparam int unsigned CNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PKT,
    WR_DROP
  } wr_state_t;

  // Saturating add of a small increment onto a statistics counter.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {{(CNT_WIDTH - 1){1'b0}}, inc};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_pkt_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when not enabled.
module fir_pkt_ram #(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fir_pkt_buffer.sv
// Store-and-forward packet buffer: absorbs an unthrottled Avalon-ST stream and
// releases only complete, well-framed packets to a backpressured source.
module fir_pkt_buffer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 6,
  parameter int unsigned MIN_PKT_WORDS = MIN_PKT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned EW = DATA_WIDTH + 2;
  localparam int unsigned LW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] len_q, len_d;
  logic [1:0]    drop_inc;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [EW-1:0]         ram_wdata;
  logic                  ram_re;
  logic [EW-1:0]         ram_rdata;
  logic                  ram_vld_q;

  logic                  out_valid_q, out_sop_q, out_eop_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  in_ready_q;
  logic [CNT_WIDTH-1:0]  drop_count_q, pkt_count_q;

  logic full, start_full, can_fetch, advance;

  // The packet start is always wr_commit, so rewinding to it can never pass the commit point.
  assign full       = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign start_full = (wr_commit_q - rd_ptr_q) == DEPTH;
  assign ram_wdata  = {in_sop, in_eop, in_data};

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    len_d       = len_q;
    drop_inc    = 2'd0;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q[ADDR_WIDTH-1:0];
    if (in_valid) begin
      if (in_sop) begin
        if (state_q == WR_PKT) drop_inc = 2'd1;
        wr_ptr_d  = wr_commit_q;
        ram_waddr = wr_commit_q[ADDR_WIDTH-1:0];
        if (start_full) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = in_eop ? WR_IDLE : WR_DROP;
        end else if (in_eop && (MIN_PKT_WORDS > 1)) begin
          drop_inc = drop_inc + 2'd1;
          state_d  = WR_IDLE;
        end else if (in_eop) begin
          ram_we      = 1'b1;
          wr_ptr_d    = wr_commit_q + PW'(1);
          wr_commit_d = wr_commit_q + PW'(1);
          state_d     = WR_IDLE;
        end else begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_commit_q + PW'(1);
          len_d    = LW'(1);
          state_d  = WR_PKT;
        end
      end else begin
        unique case (state_q)
          WR_PKT: begin
            if (full) begin
              wr_ptr_d = wr_commit_q;
              drop_inc = 2'd1;
              state_d  = in_eop ? WR_IDLE : WR_DROP;
            end else if (in_eop) begin
              if (len_q + LW'(1) >= LW'(MIN_PKT_WORDS)) begin
                ram_we      = 1'b1;
                wr_ptr_d    = wr_ptr_q + PW'(1);
                wr_commit_d = wr_ptr_q + PW'(1);
              end else begin
                wr_ptr_d = wr_commit_q;
                drop_inc = 2'd1;
              end
              state_d = WR_IDLE;
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
              len_d    = len_q + LW'(1);
            end
          end
          WR_DROP: if (in_eop) state_d = WR_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Two-stage show-ahead: RAM output register feeds the output register.
  assign can_fetch = rd_ptr_q != wr_commit_q;
  assign advance   = ram_vld_q && (!out_valid_q || out_ready);
  assign ram_re    = can_fetch && (!ram_vld_q || advance);
  assign rd_ptr_d  = rd_ptr_q + PW'(ram_re);

  fir_pkt_ram #(
    .WIDTH      (EW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      ram_vld_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      drop_count_q <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      in_ready_q   <= (wr_ptr_d - rd_ptr_d) != DEPTH;
      drop_count_q <= sat_add(drop_count_q, drop_inc);
      if (ram_re) begin
        ram_vld_q <= 1'b1;
      end else if (advance) begin
        ram_vld_q <= 1'b0;
      end
      if (advance) begin
        out_valid_q <= 1'b1;
        out_sop_q   <= ram_rdata[EW-1];
        out_eop_q   <= ram_rdata[EW-2];
        out_data_q  <= ram_rdata[DATA_WIDTH-1:0];
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready && out_eop_q) begin
        pkt_count_q <= sat_add(pkt_count_q, 2'd1);
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_data   = out_data_q;
  assign drop_count = drop_count_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_fir_pkt_buffer.sv
// Directed bench for fir_pkt_buffer with a packet-level framing model and scoreboard.
module tb_fir_pkt_buffer;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MINW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_valid, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [15:0]   drop_count, pkt_count;

  int rdy_mode = 1;  // 0: stall, 1: always ready, 2: toggle
  int total = 0;
  int bad = 0;

  typedef logic [DW+1:0] word_t;  // {sop, eop, data}
  word_t exp_q[$];
  word_t cur[$];
  bit    in_pkt;
  int    m_drops, m_sent, n_out;

  fir_pkt_buffer #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .MIN_PKT_WORDS (MINW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_ready   (in_ready),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .drop_count (drop_count),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard compare, then the framing model: a packet survives only if it starts with
  // sop, ends with eop, has MINW..DEPTH words, and is not cut short by another sop.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      cur.delete();
      in_pkt  = 0;
      m_drops = 0;
      m_sent  = 0;
      n_out   = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h expected no word", {out_sop, out_eop, out_data});
        end else begin
          check("out_word", 64'({out_sop, out_eop, out_data}), 64'(exp_q[0]));
          if (out_ready) begin
            if (exp_q[0][DW]) m_sent++;
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid) begin
        if (in_sop) begin
          if (in_pkt) m_drops++;
          cur.delete();
          in_pkt = 1;
        end
        if (in_pkt) begin
          cur.push_back({in_sop, in_eop, in_data});
          if (in_eop) begin
            if (cur.size() < MINW || cur.size() > DEPTH) m_drops++;
            else foreach (cur[i]) exp_q.push_back(cur[i]);
            in_pkt = 0;
          end
        end
      end
    end
  end

  task automatic send_word(input bit s, input bit e, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int len, input logic [DW-1:0] base, input logic [DW-1:0] trl);
    for (int i = 0; i < len; i++)
      send_word(i == 0, i == len - 1, (i == len - 1) ? trl : base + 16'(i));
  endtask

  task automatic do_reset();
    idle(0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    idle(0);
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int lat;

    // Reset values and in_ready release timing
    #1;
    check("reset_outputs",
          64'({in_ready, out_valid, out_sop, out_eop, out_data, drop_count, pkt_count}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Single packet, always ready
    rdy_mode = 1;
    idle(2);
    send_pkt(12, 16'hA000, 16'h0003);
    idle(0);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_latency", 64'(lat), 64'd2);
    check("first_word", 64'({out_sop, out_eop, out_data}), 64'({1'b1, 1'b0, 16'hA000}));
    wait_drain("single");
    check("single_pkt_count", 64'(pkt_count), 64'd1);
    check("single_words", 64'(n_out), 64'd12);
    check("single_model_sent", 64'(m_sent), 64'd1);
    check("single_drops", 64'(drop_count), 64'd0);

    // Backpressure: ready toggles every cycle
    do_reset();
    rdy_mode = 2;
    send_pkt(12, 16'hB000, 16'h0003);
    wait_drain("backpressure");
    check("bp_pkt_count", 64'(pkt_count), 64'd1);
    check("bp_words", 64'(n_out), 64'd12);

    // Overflow of a 16-entry buffer with the output stalled
    do_reset();
    rdy_mode = 0;
    send_pkt(20, 16'hC000, 16'h0003);
    idle(5);
    check("ovf_no_output", 64'(out_valid), 64'd0);
    check("ovf_drop_count", 64'(drop_count), 64'd1);
    check("ovf_model_drops", 64'(m_drops), 64'd1);
    rdy_mode = 1;
    send_pkt(6, 16'hC100, 16'h0007);
    wait_drain("overflow");
    check("ovf_pkt_count", 64'(pkt_count), 64'd1);
    check("ovf_words", 64'(n_out), 64'd6);

    // Framing errors: truncated by sop, too short, orphans
    do_reset();
    rdy_mode = 1;
    send_word(1'b1, 1'b0, 16'hD000);
    send_word(1'b0, 1'b0, 16'hD001);
    send_word(1'b0, 1'b0, 16'hD002);
    send_word(1'b0, 1'b0, 16'hD003);
    send_pkt(6, 16'hD100, 16'h0005);
    send_pkt(2, 16'hD200, 16'h0001);
    send_word(1'b0, 1'b0, 16'hE000);
    send_word(1'b0, 1'b0, 16'hE001);
    send_word(1'b0, 1'b1, 16'hE002);
    wait_drain("framing");
    check("frm_drop_count", 64'(drop_count), 64'd2);
    check("frm_model_drops", 64'(m_drops), 64'd2);
    check("frm_pkt_count", 64'(pkt_count), 64'd1);
    check("frm_words", 64'(n_out), 64'd6);

    // Pointer wrap: 10 back-to-back packets
    do_reset();
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) send_pkt(12, 16'(k * 256), 16'h0003);
    wait_drain("wrap");
    check("wrap_pkt_count", 64'(pkt_count), 64'd10);
    check("wrap_drop_count", 64'(drop_count), 64'd0);
    check("wrap_words", 64'(n_out), 64'd120);

    // Reset while a packet is arriving and another is leaving
    do_reset();
    rdy_mode = 1;
    send_pkt(6, 16'hF000, 16'h0003);
    send_word(1'b1, 1'b0, 16'hF100);
    send_word(1'b0, 1'b0, 16'hF101);
    send_word(1'b0, 1'b0, 16'hF102);
    check("mid_out_word2", 64'({out_valid, out_data}), 64'({1'b1, 16'hF001}));
    in_valid = 1'b1;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = 16'hF103;
    reset    = 1'b1;
    #1;
    check("mid_reset_outputs",
          64'({in_ready, out_valid, out_sop, out_eop, out_data, drop_count, pkt_count}), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    send_pkt(6, 16'hF200, 16'h0003);
    wait_drain("after_reset");
    check("ar_pkt_count", 64'(pkt_count), 64'd1);
    check("ar_words", 64'(n_out), 64'd6);
    check("ar_drop_count", 64'(drop_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
